// File: rtl/gear_pkg.sv
// Shared widths, step table and sequencer state encoding for gear_sequencer.
package gear_pkg;

    localparam int unsigned GEAR_W = 2;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned STEP_W = 8;

    localparam logic [GEAR_W-1:0] GEAR_MAX = '1;

    // Phase increment per gear, index 0 is the slowest (~100 Hz at 40 us ticks).
    localparam logic [3:0][STEP_W-1:0] STEP_TABLE = {8'd20, 8'd10, 8'd2, 8'd1};

    typedef enum logic [1:0] {
        StHold,
        StRun,
        StWait
    } seq_state_e;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stable-level debounce for one active-low key;
// emits a single-cycle pulse on each accepted press.
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CntW = $clog2(DEB_CYCLES);

    logic            sync1_q;
    logic            sync2_q;
    logic            stable_q;
    logic            stable_d;
    logic            press_q;
    logic            press_d;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Counter only advances while the synchronized level disagrees with the
    // accepted level; any agreement restarts the stability window.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
                stable_d = sync2_q;
                press_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= key_n;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/gear_sequencer.sv
// Sample-tick divider, phase accumulator and wrap-deferred gear selection for
// the function generator datapath.
module gear_sequencer
    import gear_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2000,
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_up_n,
    input  logic              key_dn_n,
    input  logic              run_en,
    output logic [GEAR_W-1:0] gear,
    output logic [STEP_W-1:0] f_step,
    output logic [ADDR_W-1:0] phase_addr,
    output logic              sample_tick,
    output logic              wrap,
    output logic              pending
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DivW-1:0]   div_q;
    logic [DivW-1:0]   div_d;
    logic [ADDR_W-1:0] phase_q;
    logic [ADDR_W-1:0] phase_d;
    logic [GEAR_W-1:0] gear_q;
    logic [GEAR_W-1:0] gear_d;
    logic [GEAR_W-1:0] tgt_q;
    logic [GEAR_W-1:0] tgt_d;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    logic              tick_q;
    logic              tick_d;
    logic              wrap_q;
    logic              wrap_d;
    logic              pend_q;
    logic              pend_d;
    seq_state_e        state_q;
    seq_state_e        state_d;

    logic              up_ev;
    logic              dn_ev;
    logic              fire;
    logic [ADDR_W:0]   sum;

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_key_up (
        .clk  (clk),
        .rst_n(rst_n),
        .key_n(key_up_n),
        .press(up_ev)
    );

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_key_dn (
        .clk  (clk),
        .rst_n(rst_n),
        .key_n(key_dn_n),
        .press(dn_ev)
    );

    assign sum  = {1'b0, phase_q} + {1'b0, step_q};
    assign fire = run_en && (div_q == DivW'(CLK_DIV - 1));

    // Simultaneous up/down events cancel; target saturates at both ends.
    always_comb begin
        tgt_d = tgt_q;
        if (up_ev && !dn_ev && (tgt_q != GEAR_MAX)) begin
            tgt_d = tgt_q + 1'b1;
        end else if (dn_ev && !up_ev && (tgt_q != '0)) begin
            tgt_d = tgt_q - 1'b1;
        end
    end

    always_comb begin
        div_d   = div_q;
        phase_d = phase_q;
        gear_d  = gear_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        state_d = state_q;

        if (run_en) begin
            div_d = fire ? '0 : div_q + 1'b1;
            if (fire) begin
                tick_d  = 1'b1;
                phase_d = sum[ADDR_W-1:0];
                wrap_d  = sum[ADDR_W];
            end
        end else begin
            div_d = '0;
        end

        // While idle a new gear takes effect at once; while generating it is
        // held back until the address wraps so no period is truncated.
        case (state_q)
            StHold, StRun: begin
                if (!run_en) begin
                    gear_d = tgt_d;
                end
            end
            StWait: begin
                if (!run_en) begin
                    gear_d = tgt_d;
                end else if (fire && sum[ADDR_W]) begin
                    gear_d = tgt_q;
                end
            end
            default: begin
                gear_d = tgt_d;
            end
        endcase

        if (!run_en) begin
            state_d = StHold;
        end else if (tgt_d != gear_d) begin
            state_d = StWait;
        end else begin
            state_d = StRun;
        end

        step_d = STEP_TABLE[gear_d];
        pend_d = (tgt_d != gear_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            phase_q <= '0;
            gear_q  <= '0;
            tgt_q   <= '0;
            step_q  <= STEP_TABLE[0];
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            pend_q  <= 1'b0;
            state_q <= StHold;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
            gear_q  <= gear_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            pend_q  <= pend_d;
            state_q <= state_d;
        end
    end

    assign gear        = gear_q;
    assign f_step      = step_q;
    assign phase_addr  = phase_q;
    assign sample_tick = tick_q;
    assign wrap        = wrap_q;
    assign pending     = pend_q;

endmodule

// File: tb/tb_gear_sequencer.sv
// Directed bench for gear_sequencer with a tick scoreboard (CLK_DIV=4, DEB_CYCLES=3).
module tb_gear_sequencer;

    logic       clk;
    logic       rst_n;
    logic       key_up_n;
    logic       key_dn_n;
    logic       run_en;
    logic [1:0] gear;
    logic [7:0] f_step;
    logic [7:0] phase_addr;
    logic       sample_tick;
    logic       wrap;
    logic       pending;

    typedef struct packed {
        logic [7:0] phase;
        logic       wrp;
        logic [1:0] gr;
        logic [7:0] step;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_tick_cyc = 0;
    int   last_gap = 0;
    int   model_phase = 0;

    gear_sequencer #(
        .CLK_DIV   (4),
        .DEB_CYCLES(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_up_n   (key_up_n),
        .key_dn_n   (key_dn_n),
        .run_en     (run_en),
        .gear       (gear),
        .f_step     (f_step),
        .phase_addr (phase_addr),
        .sample_tick(sample_tick),
        .wrap       (wrap),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push_steps(input int n, input logic [1:0] g, input logic [7:0] s);
        for (int i = 0; i < n; i++) begin
            int nxt;
            exp_t e;
            nxt = model_phase + int'(s);
            e.phase = 8'(nxt % 256);
            e.wrp = (nxt >= 256);
            e.gr = g;
            e.step = s;
            q.push_back(e);
            model_phase = nxt % 256;
        end
    endtask

    task automatic wait_empty(input string tag, input int budget);
        int k;
        k = 0;
        while (q.size() != 0 && k < budget) begin
            cyc_wait(1);
            k++;
        end
        check(tag, q.size(), 0);
    endtask

    task automatic press(input bit up, input bit dn, input int hold);
        key_up_n = ~up;
        key_dn_n = ~dn;
        cyc_wait(hold);
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
        cyc_wait(8);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc_wait(3);
        rst_n = 1'b1;
        model_phase = 0;
        cyc_wait(1);
    endtask

    // Scoreboard monitor: every sample_tick must match the next queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (sample_tick === 1'b1) begin
                last_gap = cyc - last_tick_cyc;
                last_tick_cyc = cyc;
                check("tick_expected", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    check("tick_phase", phase_addr, e.phase);
                    check("tick_wrap", wrap, e.wrp);
                    check("tick_gear", gear, e.gr);
                    check("tick_fstep", f_step, e.step);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int k;
        int bounce[7];
        bounce = '{1, 2, 1, 1, 2, 1, 2};

        rst_n    = 1'b0;
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
        run_en   = 1'b0;
        cyc_wait(3);
        check("rst_gear", gear, 0);
        check("rst_fstep", f_step, 1);
        check("rst_phase", phase_addr, 0);
        check("rst_tick", sample_tick, 0);
        check("rst_wrap", wrap, 0);
        check("rst_pending", pending, 0);
        rst_n = 1'b1;
        cyc_wait(2);

        // Free run at gear 0 through one full address wrap.
        push_steps(256, 2'd0, 8'd1);
        run_en = 1'b1;
        start = cyc;
        k = 0;
        while (sample_tick !== 1'b1 && k < 20) begin
            cyc_wait(1);
            k++;
        end
        check("first_tick_latency", cyc - start, 4);
        wait_empty("run_gear0_done", 1200);
        check("tick_period", last_gap, 4);
        run_en = 1'b0;
        cyc_wait(6);

        // Idle gear changes commit immediately and saturate at 3.
        press(1'b1, 1'b0, 10);
        check("hold_up1_gear", gear, 1);
        check("hold_up1_fstep", f_step, 2);
        check("hold_up1_pending", pending, 0);
        press(1'b1, 1'b0, 8);
        check("hold_up2_fstep", f_step, 10);
        press(1'b1, 1'b0, 8);
        press(1'b1, 1'b0, 8);
        check("hold_sat_gear", gear, 3);
        check("hold_sat_fstep", f_step, 20);
        for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 8);
        check("hold_down_gear", gear, 0);
        check("hold_phase_held", phase_addr, 0);

        // Running gear change deferred to the wrap.
        push_steps(100, 2'd0, 8'd1);
        run_en = 1'b1;
        wait_empty("run_to_100", 500);
        check("at_100_phase", phase_addr, 100);
        push_steps(155, 2'd0, 8'd1);
        q.push_back('{phase: 8'd0, wrp: 1'b1, gr: 2'd1, step: 8'd2});
        model_phase = 0;
        push_steps(1, 2'd1, 8'd2);
        press(1'b1, 1'b0, 8);
        check("wait_pending", pending, 1);
        check("wait_gear_held", gear, 0);
        wait_empty("wrap_commit_done", 800);
        check("commit_pending", pending, 0);
        check("commit_gear", gear, 1);
        check("commit_phase", phase_addr, 2);
        run_en = 1'b0;
        cyc_wait(4);

        // Retarget back to the committed gear while waiting: no commit.
        do_reset();
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 8);
        check("g3_gear", gear, 3);
        push_steps(14, 2'd3, 8'd20);
        run_en = 1'b1;
        press(1'b0, 1'b1, 8);
        check("retarget_pending_up", pending, 1);
        press(1'b1, 1'b0, 8);
        check("retarget_pending_down", pending, 0);
        wait_empty("retarget_done", 200);
        check("retarget_gear", gear, 3);
        check("retarget_phase", phase_addr, 24);
        run_en = 1'b0;
        cyc_wait(4);

        // Bouncing down key yields one event.
        for (int i = 0; i < 7; i++) begin
            key_dn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            cyc_wait(bounce[i]);
        end
        key_dn_n = 1'b0;
        cyc_wait(10);
        key_dn_n = 1'b1;
        cyc_wait(8);
        check("bounce_gear", gear, 2);
        check("bounce_fstep", f_step, 10);

        // Up and down events in the same cycle cancel.
        press(1'b1, 1'b1, 8);
        check("both_gear", gear, 2);
        check("both_pending", pending, 0);

        // Reset while a change is pending at phase 77.
        do_reset();
        push_steps(77, 2'd0, 8'd1);
        run_en = 1'b1;
        press(1'b1, 1'b0, 8);
        wait_empty("run_to_77", 400);
        check("pre_rst_phase", phase_addr, 77);
        check("pre_rst_pending", pending, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_gear", gear, 0);
        check("mid_rst_fstep", f_step, 1);
        check("mid_rst_phase", phase_addr, 0);
        check("mid_rst_tick", sample_tick, 0);
        check("mid_rst_wrap", wrap, 0);
        check("mid_rst_pending", pending, 0);
        for (int i = 0; i < 12; i++) begin
            cyc_wait(1);
            check("rst_no_tick", sample_tick, 0);
        end
        run_en = 1'b0;
        rst_n = 1'b1;
        cyc_wait(5);
        check("post_rst_phase", phase_addr, 0);
        check("post_rst_gear", gear, 0);
        check("final_queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
